// File: rtl/fetch_buf_pkg.sv
// Shared defaults and the buffered fetch entry type for the fetch buffer.
// Optional 0-cycle bypass in fetch_buf is enabled by defining FETCH_BUF_BYPASS_EN.
`ifndef AddrWidth
`define AddrWidth 32
`endif
`ifndef FetchBufDepth
`define FetchBufDepth 4
`endif
`ifndef FetchSlack
`define FetchSlack 2
`endif

package fetch_buf_pkg;

  localparam int ADDR_W_DEF      = `AddrWidth;
  localparam int INST_W_DEF      = 32;
  localparam int FETCH_BUF_DEPTH = `FetchBufDepth;
  localparam int FETCH_SLACK     = `FetchSlack;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
  } FetchEnt_t;

  // Occupancy at which fetch must stop so in-flight returns still fit.
  function automatic int stall_level(input int depth, input int slack);
    return depth - slack;
  endfunction

endpackage

// File: rtl/fetch_buf_if.sv
// Fetch-return / decode / flush signal bundle around the fetch buffer.
interface fetch_buf_if
  import fetch_buf_pkg::*;
#(
  parameter int ADDR = ADDR_W_DEF,
  parameter int INST = INST_W_DEF
);
  logic            inst_e_;
  logic [INST-1:0] inst;
  logic [ADDR-1:0] inst_pc;
  logic            fetch_stall_;
  logic            dec_e_;
  logic [INST-1:0] dec_inst;
  logic [ADDR-1:0] dec_pc;
  logic            dec_stall;
  logic            wb_flush_;
  logic            ovf_err;

  modport master (
    output inst_e_, inst, inst_pc, dec_stall, wb_flush_,
    input  fetch_stall_, dec_e_, dec_inst, dec_pc, ovf_err
  );

  modport slave (
    input  inst_e_, inst, inst_pc, dec_stall, wb_flush_,
    output fetch_stall_, dec_e_, dec_inst, dec_pc, ovf_err
  );
endinterface

// File: rtl/fetch_buf_ptr.sv
// Ring-buffer bookkeeping for fetch_buf: read/write pointers and occupancy.
module fetch_buf_ptr
  import fetch_buf_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  output logic [PW-1:0] rd_ptr,
  output logic [PW-1:0] wr_ptr,
  output logic [PW:0]   cnt,
  output logic          full,
  output logic          empty
);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      cnt    <= cnt + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);

endmodule

// File: rtl/fetch_buf.sv
// Instruction buffer between fetch and decode with fetch throttling and flush.
// Define FETCH_BUF_BYPASS_EN for a 0-cycle path from fetch return to decode when empty.
module fetch_buf
  import fetch_buf_pkg::*;
#(
  parameter int ADDR  = ADDR_W_DEF,
  parameter int INST  = INST_W_DEF,
  parameter int DEPTH = FETCH_BUF_DEPTH,
  parameter int SLACK = FETCH_SLACK
) (
  input logic        clk,
  input logic        reset,
  fetch_buf_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR + INST;
  localparam logic [PW:0] STALL_AT = (PW+1)'(stall_level(DEPTH, SLACK));

  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   cnt;
  logic          full, empty, flush, pop, push, byp_take;
  logic          ovf_q;

  assign flush = !bus.wb_flush_;
  assign head  = mem[rd_ptr];
  assign pop   = !empty && !bus.dec_stall;

`ifdef FETCH_BUF_BYPASS_EN
  // An empty buffer forwards the return; if decode takes it, it is never stored.
  assign byp_take     = empty && !flush && !bus.inst_e_ && !bus.dec_stall;
  assign bus.dec_e_   = (empty && !flush) ? bus.inst_e_ : empty;
  assign bus.dec_inst = (empty && !flush) ? bus.inst    : head[INST-1:0];
  assign bus.dec_pc   = (empty && !flush) ? bus.inst_pc : head[EW-1:INST];
`else
  assign byp_take     = 1'b0;
  assign bus.dec_e_   = empty;
  assign bus.dec_inst = head[INST-1:0];
  assign bus.dec_pc   = head[EW-1:INST];
`endif

  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign push = !bus.inst_e_ && !byp_take && (!full || pop);

  fetch_buf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_ptr (
    .clk    (clk),
    .reset  (reset),
    .push   (push),
    .pop    (pop),
    .flush  (flush),
    .rd_ptr (rd_ptr),
    .wr_ptr (wr_ptr),
    .cnt    (cnt),
    .full   (full),
    .empty  (empty)
  );

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {bus.inst_pc, bus.inst};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (!bus.inst_e_ && full && !pop && !flush) begin
      ovf_q <= 1'b1;
    end
  end

  assign bus.ovf_err      = ovf_q;
  assign bus.fetch_stall_ = !(cnt >= STALL_AT);

endmodule

// File: doc/fetch_buf.md
Name: fetch_buf

Overview:
- Instruction buffer between the fetch stage (fetch control plus I-cache return) and decode.
- Captures fetched (pc, inst) pairs, presents them in order to decode, and absorbs decode stalls.
- Throttles fetch through an active-low stall, leaving slack for instructions already in flight.
- Cleared in one cycle by the writeback flush.

Parameters:
- ADDR, `AddrWidth (32): PC width.
- INST, 32: instruction word width.
- DEPTH, 4: buffer entries; power of two, at least 2.
- SLACK, 2: in-flight fetches that may still arrive after fetch_stall_ asserts; 1 ≤ SLACK < DEPTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- inst_e_  in  1  active-low: fetched instruction valid this cycle.
- inst  in  INST  fetched instruction word.
- inst_pc  in  ADDR  PC of inst.
- fetch_stall_  out  1  active-low: fetch must stop issuing new PCs.
- dec_e_  out  1  active-low: head entry valid to decode.
- dec_inst  out  INST  head instruction.
- dec_pc  out  ADDR  head PC.
- dec_stall  in  1  active-high: decode does not accept the head.
- wb_flush_  in  1  active-low: flush all buffered instructions.
- ovf_err  out  1  sticky: a push was dropped because the buffer was full.

Behaviour:
- Storage and pointers:
  - Ring buffer of DEPTH entries.
  - rd_ptr and wr_ptr are $clog2(DEPTH) bits wide and wrap naturally.
  - cnt is $clog2(DEPTH)+1 bits wide, range 0..DEPTH.
- Reset (sync, reset=1 at posedge): rd_ptr=wr_ptr=cnt=0 and ovf_err=0, so dec_e_=1 and fetch_stall_=1. Entry data is not reset.
- pop = !dec_e_ && !dec_stall.
- push = !inst_e_ && (cnt<DEPTH || pop).
  - A push into a full buffer is allowed in the same cycle as a pop.
- Push with cnt==DEPTH and no pop: the entry is dropped, state is unchanged, and ovf_err sets at the next edge. It stays set until reset.
- Each edge:
  - mem[wr_ptr] <= {inst_pc, inst} on push.
  - wr_ptr += push; rd_ptr += pop; cnt += push − pop.
- Decode outputs:
  - dec_e_ = (cnt==0).
  - dec_inst and dec_pc = mem[rd_ptr].
  - All three are combinational from registers.
- Latency: an instruction pushed at edge N is visible at decode in the cycle after edge N (1 cycle).
- Stall: fetch_stall_ = !(cnt >= DEPTH−SLACK), combinational from cnt. With DEPTH=4 and SLACK=2, fetch stalls at cnt≥2.
- Flush (wb_flush_=0), highest priority:
  - At the edge: rd_ptr=wr_ptr=cnt=0.
  - Any push or pop in the same cycle is ignored.
  - ovf_err is unaffected.
  - In the flush cycle itself dec_e_ still reflects the current cnt; decode must discard it because it receives wb_flush_ too.
- reset takes priority over flush.
- Ordering is strictly FIFO; no reordering.

Optional Feature:
- Macro: FETCH_BUF_BYPASS_EN.
- Defined:
  - When cnt==0 and wb_flush_=1, the input passes straight through: dec_e_=inst_e_, dec_inst=inst, dec_pc=inst_pc (0-cycle latency).
  - If decode accepts (dec_stall=0), the entry is not written and counters are unchanged.
  - If dec_stall=1, it is pushed normally.
- Not defined: no combinational path from inst* to dec*; 1-cycle latency always.

Decomposition:
- cpu_if.svh carries typedef struct packed { logic [ADDR-1:0] pc; logic [INST-1:0] inst; } FetchEnt_t.
- cpu_config.svh carries `FetchBufDepth (4) and `FetchSlack (2) as parameter defaults.
- One natural sub-module: fetch_buf_ptr, holding the rd/wr pointers and cnt with push/pop/flush inputs and full/empty/cnt outputs. Storage and output muxing stay in fetch_buf.

Test Plan:
- Reset, then push pc=0x100/0x104/0x108 on 3 consecutive cycles with dec_stall=0 → dec_pc shows 0x100,0x104,0x108 one cycle after each push (same cycle with bypass); fetch_stall_ stays 1.
- dec_stall=1 and push 0x200..0x20c (4 pushes) → fetch_stall_ goes 0 after the 2nd push; cnt=4; release the stall → drains in order, and fetch_stall_ returns to 1 when cnt<2.
- Full (cnt=4), a 5th push with dec_stall=1 → entry dropped, ovf_err=1 next cycle, head still 0x200; repeat with dec_stall=0 → push and pop both occur, cnt stays 4, ovf_err unchanged.
- cnt=3 and wb_flush_=0 together with a push → next cycle dec_e_=1, cnt=0, fetch_stall_=1; the next push appears as the new head.
- Wrap-around: 10 push/pop pairs, pc 0x0..0x24 step 4 → outputs in order across pointer wrap, with no duplicate or lost entry.
- reset=1 asserted mid-operation with cnt=2 and a push/pop pending → next cycle cnt=0, dec_e_=1, ovf_err=0; a simultaneous wb_flush_=0 has no extra effect.
